// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uio_bus_arbiter
// Purpose  : Round-robin owner selection for the shared uio pad bank, with a
//            bounded hold time and an all-release turnaround between owners.
// Revision : 1.0 - initial release
// ============================================================================
module uio_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_MAX    = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_out,
  input  logic [8*NREQ-1:0] req_oe,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        owner,
  output logic              busy,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int c_HOLD_W = $clog2(HOLD_MAX);
  localparam int c_TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_MAX - 1);
  localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NREQ-1:0]     r_grant;
  logic [2:0]          r_owner;
  logic [2:0]          r_ptr;
  logic [c_HOLD_W-1:0] r_hold;
  logic [c_TURN_W-1:0] r_turn;

  logic [7:0] w_req_ext;
  logic [3:0] w_idx;
  logic       w_any;
  logic [2:0] w_winner;
  logic       w_others;
  logic       w_release;
  logic [2:0] w_next_ptr;

  always_comb begin
    w_req_ext           = '0;
    w_req_ext[NREQ-1:0] = req;
  end

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = 4'(r_ptr) + 4'(k);
      if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
      if (!w_any && w_req_ext[w_idx[2:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  assign w_others   = |(w_req_ext & ~(8'd1 << r_owner));
  assign w_release  = !w_req_ext[r_owner] || ((r_hold == c_HOLD_LAST) && w_others);
  assign w_next_ptr = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;

  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (r_state == ST_GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_owner == 3'(i)) begin
          uio_out = req_out[8*i +: 8];
          uio_oe  = req_oe[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= NREQ'(1) << w_winner;
            r_owner <= w_winner;
            r_hold  <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (r_hold != c_HOLD_LAST) r_hold <= r_hold + c_HOLD_W'(1);
          if (w_release) begin
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_turn  <= '0;
            r_state <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (r_turn == c_TURN_LAST) begin
            if (w_any) begin
              r_grant <= NREQ'(1) << w_winner;
              r_owner <= w_winner;
              r_hold  <= '0;
              r_state <= ST_GRANT;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_turn <= r_turn + c_TURN_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uio_bus_arbiter
// Purpose  : Scoreboard bench for uio_bus_arbiter (TURN_CYCLES=1 and =3 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_out;
    logic [31:0] req_oe;

    logic [3:0] grant_a, grant_b;
    logic [2:0] owner_a, owner_b;
    logic       busy_a, busy_b;
    logic [7:0] uio_out_a, uio_out_b;
    logic [7:0] uio_oe_a, uio_oe_b;

    always #5 clk = ~clk;

    uio_bus_arbiter #(.NREQ(4), .HOLD_MAX(16), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_out(req_out), .req_oe(req_oe),
        .grant(grant_a), .owner(owner_a), .busy(busy_a),
        .uio_out(uio_out_a), .uio_oe(uio_oe_a)
    );

    uio_bus_arbiter #(.NREQ(4), .HOLD_MAX(16), .TURN_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_out(req_out), .req_oe(req_oe),
        .grant(grant_b), .owner(owner_b), .busy(busy_b),
        .uio_out(uio_out_b), .uio_oe(uio_oe_b)
    );

    typedef struct packed {
        logic       sel;
        logic [3:0] g;
        logic [2:0] o;
        logic       b;
        logic [7:0] d;
        logic [7:0] e;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    string      phase    = "reset";
    logic [7:0] dat [4];

    function automatic exp_t e_grant(input logic s, input int o);
        exp_t x;
        x.sel = s; x.g = 4'(1 << o); x.o = 3'(o); x.b = 1'b1; x.d = dat[o]; x.e = 8'hFF;
        return x;
    endfunction

    function automatic exp_t e_turn(input logic s, input int o);
        exp_t x;
        x.sel = s; x.g = 4'd0; x.o = 3'(o); x.b = 1'b1; x.d = 8'h00; x.e = 8'h00;
        return x;
    endfunction

    function automatic exp_t e_idle(input logic s, input int o);
        exp_t x;
        x.sel = s; x.g = 4'd0; x.o = 3'(o); x.b = 1'b0; x.d = 8'h00; x.e = 8'h00;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        exp_t a;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            if (x.sel) a = {1'b1, grant_b, owner_b, busy_b, uio_out_b, uio_oe_b};
            else       a = {1'b0, grant_a, owner_a, busy_a, uio_out_a, uio_oe_a};
            n_checks++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL %s t=%0t: got grant=%b owner=%0d busy=%b uio_out=%h uio_oe=%h, required grant=%b owner=%0d busy=%b uio_out=%h uio_oe=%h",
                         phase, $time, a.g, a.o, a.b, a.d, a.e, x.g, x.o, x.b, x.d, x.e);
            end
        end
    end

    task automatic step(input exp_t x);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        n_checks++;
        if (grant_a !== 4'd0 || busy_a !== 1'b0 || owner_a !== 3'd0 ||
            uio_oe_a !== 8'h00 || uio_out_a !== 8'h00) begin
            n_fail++;
            $display("FAIL %s t=%0t: dut_a not in reset state: grant=%b busy=%b owner=%0d uio_out=%h uio_oe=%h",
                     phase, $time, grant_a, busy_a, owner_a, uio_out_a, uio_oe_a);
        end
        n_checks++;
        if (grant_b !== 4'd0 || busy_b !== 1'b0 || owner_b !== 3'd0 ||
            uio_oe_b !== 8'h00 || uio_out_b !== 8'h00) begin
            n_fail++;
            $display("FAIL %s t=%0t: dut_b not in reset state: grant=%b busy=%b owner=%0d uio_out=%h uio_oe=%h",
                     phase, $time, grant_b, busy_b, owner_b, uio_out_b, uio_oe_b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h5A; dat[3] = 8'hC3;
        for (int i = 0; i < 4; i++) req_out[8*i +: 8] = dat[i];
        req_oe = '1;
        rst    = 1'b1;
        req    = '0;
        @(posedge clk);
        #1;
        chk_reset_state();

        phase = "reset_state";
        step(e_idle(0, 0));

        phase = "single_req";
        rst = 1'b0;
        req = 4'b0001;
        step(e_idle(0, 0));
        step(e_grant(0, 0));
        req = 4'b0000;
        step(e_grant(0, 0));
        step(e_turn(0, 0));
        step(e_idle(0, 0));

        phase = "round_robin";
        do_reset();
        req = 4'b1111;
        step(e_idle(0, 0));
        for (int o = 0; o < 4; o++) begin
            repeat (16) step(e_grant(0, o));
            step(e_turn(0, o));
        end
        repeat (2) step(e_grant(0, 0));

        phase = "saturate";
        do_reset();
        req = 4'b0100;
        step(e_idle(0, 0));
        repeat (60) step(e_grant(0, 2));
        req = 4'b0101;
        step(e_grant(0, 2));
        step(e_turn(0, 2));
        step(e_grant(0, 0));

        phase = "ptr_wrap";
        do_reset();
        req = 4'b1000;
        step(e_idle(0, 0));
        step(e_grant(0, 3));
        req = 4'b1001;
        repeat (15) step(e_grant(0, 3));
        step(e_turn(0, 3));
        step(e_grant(0, 0));

        phase = "reset_mid_grant";
        rst = 1'b1;
        step(e_grant(0, 0));
        chk_reset_state();
        rst = 1'b0;
        req = 4'b0010;
        step(e_idle(0, 0));
        n_checks++;
        if (grant_a !== 4'b0010 || owner_a !== 3'd1) begin
            n_fail++;
            $display("FAIL %s t=%0t: after reset expected grant=0010 owner=1, got grant=%b owner=%0d",
                     phase, $time, grant_a, owner_a);
        end
        step(e_grant(0, 1));

        phase = "turn3";
        do_reset();
        req = 4'b0001;
        step(e_idle(1, 0));
        step(e_grant(1, 0));
        req = 4'b0010;
        step(e_grant(1, 0));
        repeat (3) step(e_turn(1, 0));
        step(e_grant(1, 1));
        req = 4'b0001;
        step(e_grant(1, 1));
        repeat (3) step(e_turn(1, 1));
        step(e_grant(1, 0));

        phase = "final";
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d scoreboard entries never checked", phase, sb_q.size());
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL %s: only %0d checks evaluated", phase, n_checks);
        end
        if (n_fail != 0) $display("FAIL %s: %0d failures recorded", phase, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
